// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: latches a 7-bit pattern and steps MuxSelect 0..6, holding each for CYCLES_PER_BIT clocks.
// Optional continuous re-pass mode with the Repeat input when MUX_SEQ_REPEAT_EN is defined.
module mux_select_sequencer #(
   parameter int CYCLES_PER_BIT = 4
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Start,
   input  logic [6:0] Pattern,
`ifdef MUX_SEQ_REPEAT_EN
   input  logic       Repeat,
`endif
   output logic [2:0] MuxSelect,
   output logic [6:0] Input,
   output logic       Valid,
   output logic       Busy,
   output logic       Done
);
   localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    sel_q, sel_d;
   logic [6:0]    in_q, in_d;
   logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         in_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         in_q    <= in_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      in_d    = in_q;
      done_d  = 1'b0;
      case (state_q)
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sel_d = sel_q + 3'd1;
               if (sel_q == 3'd6) begin
                  sel_d  = '0;
                  done_d = 1'b1;
`ifdef MUX_SEQ_REPEAT_EN
                  if (Repeat) in_d = Pattern;
                  else state_d = S_DONE;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
         default: begin
            // The edge leaving DONE also accepts Start, giving a 7N+1 cycle minimum spacing.
            sel_d   = '0;
            state_d = (state_q == S_DONE) ? S_IDLE : state_q;
            if (Start) begin
               state_d = S_RUN;
               in_d    = Pattern;
               cnt_d   = '0;
            end
         end
      endcase
      valid_d = (state_d == S_RUN);
      busy_d  = (state_d != S_IDLE);
   end

   assign MuxSelect = sel_q;
   assign Input     = in_q;
   assign Valid     = valid_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer: randomized self-checking bench for mux_select_sequencer at N=4 and N=1.
// Expected outputs come from an arithmetic model of cycle offset since the accepting Start edge.
module tb_mux_select_sequencer;
   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       start4 = 1'b0, start1 = 1'b0;
   logic [6:0] Pattern = '0;
   logic       Repeat = 1'b0;
   logic [2:0] sel4, sel1, sel;
   logic [6:0] in4, in1, inp;
   logic       v4, b4, d4, v1, b1, d1, v, b, d;
   bit         use1 = 1'b0;
   int         errors = 0, checks = 0;

   always #5 Clock = ~Clock;

   mux_select_sequencer #(.CYCLES_PER_BIT(4)) u4 (
      .Clock(Clock), .Resetn(Resetn), .Start(start4), .Pattern(Pattern),
`ifdef MUX_SEQ_REPEAT_EN
      .Repeat(Repeat),
`endif
      .MuxSelect(sel4), .Input(in4), .Valid(v4), .Busy(b4), .Done(d4));

   mux_select_sequencer #(.CYCLES_PER_BIT(1)) u1 (
      .Clock(Clock), .Resetn(Resetn), .Start(start1), .Pattern(Pattern),
`ifdef MUX_SEQ_REPEAT_EN
      .Repeat(Repeat),
`endif
      .MuxSelect(sel1), .Input(in1), .Valid(v1), .Busy(b1), .Done(d1));

   always_comb begin
      sel = use1 ? sel1 : sel4;
      inp = use1 ? in1 : in4;
      v   = use1 ? v1 : v4;
      b   = use1 ? b1 : b4;
      d   = use1 ? d1 : d4;
   end

   // {MuxSelect, Valid, Busy, Done} expected t cycles after the accepting edge
   function automatic logic [5:0] exp_at(int n, int t);
      if (t < 7 * n) return {3'(t / n), 3'b110};
      if (t == 7 * n) return 6'b000011;
      return 6'b000000;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      repeat (3) tick();
      checks++;
      if ({sel4, in4, v4, b4, d4, sel1, in1, v1, b1, d1} !== '0) begin
         errors++;
         $display("FAIL reset_hold got=%h want=0", {sel4, in4, v4, b4, d4, sel1, in1, v1, b1, d1});
      end
      Resetn = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sel4, in4, v4, b4, d4, sel1, in1, v1, b1, d1} !== '0) begin
         errors++;
         $display("FAIL reset_release got=%h want=0", {sel4, in4, v4, b4, d4, sel1, in1, v1, b1, d1});
      end
   endtask

   task automatic test_single_pass(input logic [6:0] pat, input bit poke);
      int nvalid = 0, ndone = 0;
      use1 = 1'b0;
      Pattern = pat;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int t = 0; t <= 29; t++) begin
         checks++;
         if ({sel, v, b, d} !== exp_at(4, t)) begin
            errors++;
            $display("FAIL pass_outputs t=%0d got=%b want=%b", t, {sel, v, b, d}, exp_at(4, t));
         end
         checks++;
         if (t <= 28 && inp !== pat) begin
            errors++;
            $display("FAIL pass_input t=%0d got=%b want=%b", t, inp, pat);
         end
         nvalid += int'(v);
         ndone += int'(d);
         if (poke && t == 5) begin Pattern = 7'b0000000; start4 = 1'b1; end
         if (t == 6) start4 = 1'b0;
         tick();
      end
      checks++;
      if (nvalid != 28 || ndone != 1) begin
         errors++;
         $display("FAIL pass_counts valid=%0d done=%0d want 28 and 1", nvalid, ndone);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] pat = 7'($urandom);
      use1 = 1'b0;
      Pattern = pat;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (12) tick();
      checks++;
      if ({sel, v, inp} !== {3'd3, 1'b1, pat}) begin
         errors++;
         $display("FAIL mid_before got=%h want=%h", {sel, v, inp}, {3'd3, 1'b1, pat});
      end
      #2 Resetn = 1'b0;
      #1;
      checks++;
      if ({sel4, in4, v4, b4, d4} !== '0) begin
         errors++;
         $display("FAIL mid_async got=%h want=0", {sel4, in4, v4, b4, d4});
      end
      tick();
      Resetn = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sel4, in4, v4, b4, d4} !== '0) begin
         errors++;
         $display("FAIL mid_no_resume got=%h want=0", {sel4, in4, v4, b4, d4});
      end
      test_single_pass(7'b1111111, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [6:0] pat = 7'($urandom);
      use1 = 1'b1;
      Pattern = pat;
      start1 = 1'b1;
      tick();
      for (int t = 0; t < 26; t++) begin
         checks++;
         if ({sel, v, b, d} !== (t < 24 ? exp_at(1, t % 8) : 6'b0) || (t < 24 && inp !== pat)) begin
            errors++;
            $display("FAIL b2b t=%0d got=%b/%b want=%b/%b", t, {sel, v, b, d}, inp,
                     (t < 24 ? exp_at(1, t % 8) : 6'b0), pat);
         end
         if (t == 23) start1 = 1'b0;
         tick();
      end
      use1 = 1'b0;
   endtask

   task automatic test_random();
      use1 = 1'b0;
      for (int p = 0; p < 6; p++) begin
         logic [6:0] pat = 7'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            Pattern = 7'($urandom);
            tick();
            checks++;
            if ({sel, v, b, d} !== 6'b0) begin
               errors++;
               $display("FAIL rand_idle got=%b want=000000", {sel, v, b, d});
            end
         end
         Pattern = pat;
         start4 = 1'b1;
         tick();
         for (int t = 0; t <= 29; t++) begin
            checks++;
            if ({sel, v, b, d} !== exp_at(4, t) || (t <= 28 && inp !== pat)) begin
               errors++;
               $display("FAIL rand_pass p=%0d t=%0d got=%b/%b want=%b/%b", p, t, {sel, v, b, d},
                        inp, exp_at(4, t), pat);
            end
            Pattern = 7'($urandom);
            start4 = (t < 28) ? 1'($urandom) : 1'b0;
            tick();
         end
      end
   endtask

`ifdef MUX_SEQ_REPEAT_EN
   task automatic test_repeat();
      logic [6:0] pat = 7'($urandom), exp_in, prev;
      logic [5:0] e;
      use1 = 1'b0;
      Repeat = 1'b1;
      Pattern = pat;
      exp_in = pat;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      prev = pat;
      for (int t = 0; t <= 85; t++) begin
         if (t == 28 || t == 56) exp_in = prev;
         e = (t < 84) ? {3'((t % 28) / 4), 2'b11, 1'(t == 28 || t == 56)} : exp_at(4, t - 56);
         checks++;
         if ({sel, v, b, d} !== e || (t <= 84 && inp !== exp_in)) begin
            errors++;
            $display("FAIL repeat t=%0d got=%b/%b want=%b/%b", t, {sel, v, b, d}, inp, e, exp_in);
         end
         if (t == 57) Repeat = 1'b0;
         Pattern = 7'($urandom);
         prev = Pattern;
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pass(7'b1010011, 1'b0);
      test_single_pass(7'b1010011, 1'b1);
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef MUX_SEQ_REPEAT_EN
      test_repeat();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
